// File: rtl/copperv_bus_pkg.sv
// Shared types and helpers for the copperv bus arbiters.
package copperv_bus_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_id_t;

    // Ceiling log2, used to size FIFO pointers and occupancy counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/copperv_arb_order_fifo.sv
// In-order FIFO of request source ids; DEPTH must be a power of two so
// the pointers wrap naturally.
module copperv_arb_order_fifo
    import copperv_bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  src_id_t                push_id,
    input  logic                   pop,
    output src_id_t                head,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    src_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;

    // Storage needs no reset; entries are only read below the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/copperv_read_arbiter.sv
// Shares one downstream read port between instruction and data reads.
// Optional COPPERV_ARB_ROUND_ROBIN_EN: alternate grants when both request;
// otherwise data reads have fixed priority over instruction reads.
module copperv_read_arbiter
    import copperv_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ir_addr_valid,
    output logic                  ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0] ir_addr,
    output logic                  ir_data_valid,
    input  logic                  ir_data_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    input  logic                  dr_addr_valid,
    output logic                  dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0] dr_addr,
    output logic                  dr_data_valid,
    input  logic                  dr_data_ready,
    output logic [DATA_WIDTH-1:0] dr_data,
    output logic                  m_addr_valid,
    input  logic                  m_addr_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    input  logic                  m_data_valid,
    output logic                  m_data_ready,
    input  logic [DATA_WIDTH-1:0] m_data,
    output logic                  err_unexpected_resp
);

    localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING) + 1;

    logic             slot_free;
    logic             can_accept;
    logic             accept;
    logic             resp_fire;
    logic             empty;
    logic [CNT_W-1:0] count;
    src_id_t          winner;
    src_id_t          head;

    copperv_arb_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (winner),
        .pop     (resp_fire),
        .head    (head),
        .empty   (empty),
        .count   (count)
    );

`ifdef COPPERV_ARB_ROUND_ROBIN_EN
    src_id_t last_grant;

    // Contested requests go to whichever side was not granted last.
    always_comb begin
        winner = SRC_INST;
        if (ir_addr_valid && dr_addr_valid) begin
            if (last_grant == SRC_DATA) begin
                winner = SRC_INST;
            end else begin
                winner = SRC_DATA;
            end
        end else if (dr_addr_valid) begin
            winner = SRC_DATA;
        end
    end

    // Remember the most recent grant; reset value lets ir win first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_DATA;
        end else if (accept) begin
            last_grant <= winner;
        end
    end
`else
    // Fixed priority: data reads beat instruction reads.
    always_comb begin
        winner = SRC_INST;
        if (dr_addr_valid) begin
            winner = SRC_DATA;
        end
    end
`endif

    // Grant uses registered count only, so a same-cycle response never frees a slot.
    assign slot_free     = !m_addr_valid || m_addr_ready;
    assign can_accept    = slot_free && (count < CNT_W'(MAX_OUTSTANDING));
    assign ir_addr_ready = can_accept && (winner == SRC_INST);
    assign dr_addr_ready = can_accept && (winner == SRC_DATA);
    assign accept        = (ir_addr_valid && ir_addr_ready) || (dr_addr_valid && dr_addr_ready);

    // Route the response to the oldest outstanding requester.
    always_comb begin
        ir_data_valid = 1'b0;
        dr_data_valid = 1'b0;
        m_data_ready  = 1'b0;
        if (!empty) begin
            if (head == SRC_INST) begin
                ir_data_valid = m_data_valid;
                m_data_ready  = ir_data_ready;
            end else begin
                dr_data_valid = m_data_valid;
                m_data_ready  = dr_data_ready;
            end
        end
    end

    assign resp_fire = m_data_valid && m_data_ready;
    assign ir_data   = m_data;
    assign dr_data   = m_data;

    // Downstream address register: load on grant, drop after handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_addr_valid <= 1'b0;
            m_addr       <= '0;
        end else if (accept) begin
            m_addr_valid <= 1'b1;
            if (winner == SRC_DATA) begin
                m_addr <= dr_addr;
            end else begin
                m_addr <= ir_addr;
            end
        end else if (m_addr_ready) begin
            m_addr_valid <= 1'b0;
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_unexpected_resp <= 1'b0;
        end else if (m_data_valid && empty) begin
            err_unexpected_resp <= 1'b1;
        end
    end

endmodule

// File: doc/copperv_read_arbiter.md
Name: copperv_read_arbiter

Overview:
- Shares one downstream memory read port between the CPU instruction-read channel (ir_*) and the data-read channel (dr_*).
- Sits between the copperv core and the memory/bus model.
- Arbitrates address requests and registers the winning address onto m_addr.
- Tracks the source of each outstanding request in order, and routes each m_data response back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, width of ir_addr/dr_addr/m_addr
DATA_WIDTH, 32, width of ir_data/dr_data/m_data
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests; power of two, >=2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ir_addr_valid  in  1  instruction read request valid
ir_addr_ready  out  1  instruction request accepted
ir_addr  in  ADDR_WIDTH  instruction read address
ir_data_valid  out  1  instruction read data valid
ir_data_ready  in  1  core accepts instruction data
ir_data  out  DATA_WIDTH  instruction read data
dr_addr_valid  in  1  data read request valid
dr_addr_ready  out  1  data request accepted
dr_addr  in  ADDR_WIDTH  data read address
dr_data_valid  out  1  data read data valid
dr_data_ready  in  1  core accepts data read data
dr_data  out  DATA_WIDTH  data read data
m_addr_valid  out  1  downstream read request valid (registered)
m_addr_ready  in  1  downstream accepts request
m_addr  out  ADDR_WIDTH  downstream read address (registered)
m_data_valid  in  1  downstream response valid
m_data_ready  out  1  arbiter accepts response
m_data  in  DATA_WIDTH  downstream response data
err_unexpected_resp  out  1  sticky: m_data_valid seen with no request outstanding

Behaviour:
- Reset values (rst low, asynchronous):
  - m_addr_valid=0, m_addr=0.
  - Order FIFO empty; outstanding count=0.
  - err_unexpected_resp=0.
  - Priority pointer prefers ir.
- Handshakes use valid/ready; a transfer occurs on a clock edge with both high.
  - A valid, once raised, holds with stable payload until its handshake.
- Address slot free: slot_free = !m_addr_valid || m_addr_ready.
- Grant conditions (combinational from registered state only):
  - can_accept = slot_free && (count < MAX_OUTSTANDING).
  - Winner is chosen among asserted ir_addr_valid/dr_addr_valid.
  - x_addr_ready = can_accept && winner==x; the loser's ready is 0.
  - No combinational path from any m_data_* or *_data_ready to *_addr_ready.
- On accept:
  - m_addr <= winner address; m_addr_valid <= 1.
  - Source id is pushed into the order FIFO.
  - count increments.
- m_addr handshake with no new accept: m_addr_valid <= 0.
- Latency: request accepted in cycle N appears on m_addr in cycle N+1. Back-to-back acceptance is allowed while m_addr_ready=1, giving throughput of 1 per cycle.
- Response path (combinational):
  - head = FIFO head source.
  - If FIFO non-empty: head's data_valid = m_data_valid, the other requester's data_valid = 0, and m_data_ready = head's data_ready.
  - ir_data and dr_data are both driven with m_data.
  - On response handshake: pop FIFO, count decrements.
- Count update is computed as +accept −response. Simultaneous accept and response keeps count unchanged. Accept is not permitted at count==MAX even if a response completes in the same cycle.
- FIFO empty and m_data_valid=1:
  - m_data_ready=0; both data_valids stay 0.
  - err_unexpected_resp <= 1 and holds until reset.
- Count reaches MAX_OUTSTANDING (full): both addr_ready=0 until a response completes.
- FIFO pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction discards all outstanding tracking. Responses arriving afterward set err_unexpected_resp.
- Fixed priority (macro absent): dr wins over ir when both are valid.

Optional Feature:
- Macro: COPPERV_ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last_grant register (reset = dr, so ir wins first).
  - When both requesters are valid, the requester that was not last granted wins.
  - last_grant updates on each accept.
- Undefined: fixed dr-over-ir priority; no last_grant register.

Decomposition:
- Package copperv_bus_pkg:
  - src_id_t enum: SRC_INST=0, SRC_DATA=1.
  - Function clog2 for pointer widths.
- Sub-module copperv_arb_order_fifo:
  - Parameterised-depth FIFO of src_id_t with push, pop, head, empty, count.
  - Reused for the write-channel arbiter later.

Test Plan:
- Single fetch: ir_addr=0x00000100, m_addr_ready=1, m_data=0xDEADBEEF two cycles later -> m_addr=0x100 at N+1; ir_data_valid with 0xDEADBEEF; dr_data_valid stays 0.
- Simultaneous requests, fixed priority: ir 0x200, dr 0x8000 in same cycle -> dr granted first, ir next cycle; responses 0x11, 0x22 routed dr then ir.
- Round robin (macro defined): ir and dr both valid for 4 accepts -> grant order ir, dr, ir, dr.
- Full: 4 ir requests with m_data_valid=0 -> 5th blocked with ir_addr_ready=0; one response pops; ready returns next cycle.
- Backpressure: m_addr_ready=0 for 3 cycles -> m_addr/m_addr_valid stable, no new grant. ir_data_ready=0 with response pending -> m_data_ready=0, FIFO head unchanged.
- Stray response: m_data_valid=1 with empty FIFO -> err_unexpected_resp=1, sticky; cleared only by rst low, which also zeroes m_addr_valid mid-request.
